// File: rtl/piso_bit_serializer_if.sv
// Handshake and serial-side bundle for the PISO bit serializer.
// "master" is the side that supplies words and the advance enable.
// "slave" is the serializer itself.
interface piso_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_data, in_valid, ser_en,
        input  in_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  in_data, in_valid, ser_en,
        output in_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in / serial-out stage feeding the "101" sequence detector.
// A shifter emits one bit per enabled clock. A one-word hold register lets
// the next word queue up so consecutive words stream with no idle bit.
// Every output to the detector comes straight from a flop.
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    piso_bit_serializer_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic             hold_full_reg, hold_full_next;
    logic             ser_out_reg, ser_out_next;
    logic             ser_valid_reg, ser_valid_next;
    logic             ser_last_reg, ser_last_next;
    logic             in_ready_reg, in_ready_next;

    logic             accept;
    logic             load_in;
    logic             load_held;
    logic [WIDTH-1:0] load_word;

    // Bit that goes out first for a freshly loaded word.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Remaining bits after the head bit, moved into the head position.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Next-state logic: advance, word boundary handling, and hold register fill.
    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        count_next     = count_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        ser_out_next   = ser_out_reg;
        ser_valid_next = ser_valid_reg;
        ser_last_next  = ser_last_reg;
        load_in        = 1'b0;
        load_held      = 1'b0;
        load_word      = bus.in_data;

        // in_ready is registered, so accept never depends on this cycle's state.
        accept = bus.in_valid & in_ready_reg;

        if (state_reg == SHIFT && bus.ser_en) begin
            if (!ser_last_reg) begin
                ser_out_next  = head_bit(shift_reg);
                shift_next    = drop_head(shift_reg);
                count_next    = count_reg + CW'(1);
                ser_last_next = (count_reg == CW'(WIDTH - 2));
            end else if (hold_full_reg) begin
                load_held = 1'b1;
            end else if (accept) begin
                load_in = 1'b1;
            end else begin
                state_next     = IDLE;
                count_next     = '0;
                ser_out_next   = 1'b0;
                ser_valid_next = 1'b0;
                ser_last_next  = 1'b0;
            end
        end else if (state_reg == IDLE && accept) begin
            load_in = 1'b1;
        end

        if (load_held) begin
            load_word = hold_reg;
        end

        // A new word puts its first bit on ser_out right away.
        if (load_in || load_held) begin
            state_next     = SHIFT;
            ser_out_next   = head_bit(load_word);
            shift_next     = drop_head(load_word);
            count_next     = '0;
            ser_valid_next = 1'b1;
            ser_last_next  = 1'b0;
        end

        if (load_held) begin
            hold_full_next = 1'b0;
        end

        // An accepted word that could not go to the shifter waits in hold.
        if (accept && !load_in) begin
            hold_next      = bus.in_data;
            hold_full_next = 1'b1;
        end

        in_ready_next = ~hold_full_next;
    end

    // State register. A reset discards both the word in flight and the held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            count_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            ser_out_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
            ser_last_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            count_reg     <= count_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            ser_out_reg   <= ser_out_next;
            ser_valid_reg <= ser_valid_next;
            ser_last_reg  <= ser_last_next;
            in_ready_reg  <= in_ready_next;
        end
    end

    assign bus.ser_out   = ser_out_reg;
    assign bus.ser_valid = ser_valid_reg;
    assign bus.ser_last  = ser_last_reg;
    assign bus.in_ready  = in_ready_reg;
    assign bus.busy      = ser_valid_reg | hold_full_reg;
endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer. dut_m sends MSB first and dut_l sends LSB first.
module tb_piso_bit_serializer;
    logic clk;
    logic rst;

    piso_bit_serializer_if #(.WIDTH(8)) bus_m ();
    piso_bit_serializer_if #(.WIDTH(8)) bus_l ();

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       n_vec = 0;
    int       n_err = 0;
    int       det_hits = 0;
    int       active = 0;
    logic [2:0] win = 3'b000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Step one clock and sample 1 time unit after the rising edge.
    // The sampled MSB-first stream also drives a behavioural 101 detector.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus_m.ser_valid === 1'b1) begin
            active++;
            win = {win[1:0], bus_m.ser_out};
            if (win == 3'b101) det_hits++;
        end
    endtask

    task automatic expect_bit(input string tag, input logic b, input logic last);
        check({tag, "/out"},   {31'd0, bus_m.ser_out},   {31'd0, b});
        check({tag, "/valid"}, {31'd0, bus_m.ser_valid}, 32'd1);
        check({tag, "/last"},  {31'd0, bus_m.ser_last},  {31'd0, last});
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "/valid"}, {31'd0, bus_m.ser_valid}, 32'd0);
        check({tag, "/out"},   {31'd0, bus_m.ser_out},   32'd0);
        check({tag, "/last"},  {31'd0, bus_m.ser_last},  32'd0);
        check({tag, "/busy"},  {31'd0, bus_m.busy},      32'd0);
        check({tag, "/ready"}, {31'd0, bus_m.in_ready},  32'd1);
    endtask

    // Send one word to dut_m alone and check its 8 bits, MSB first.
    task automatic stream_word(input string tag, input logic [7:0] w);
        bus_m.in_data  = w;
        bus_m.in_valid = 1'b1;
        tick();
        bus_m.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            expect_bit($sformatf("%s.b%0d", tag, k), w[7-k], k == 7);
            tick();
        end
        expect_idle({tag, ".end"});
        $display("word %02h streamed (%s)", w, tag);
    endtask

    logic [15:0] pair;

    initial begin
        rst            = 1'b1;
        bus_m.in_data  = '0;
        bus_m.in_valid = 1'b0;
        bus_m.ser_en   = 1'b1;
        bus_l.in_data  = '0;
        bus_l.in_valid = 1'b0;
        bus_l.ser_en   = 1'b1;
        #12;
        expect_idle("reset");
        check("reset/l_valid", {31'd0, bus_l.ser_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single word A0. Its only 101 pattern is at the start.
        win = 3'b000;
        det_hits = 0;
        stream_word("t1", 8'hA0);
        check("t1/det_hits", det_hits, 32'd1);

        // 2: back-to-back A5 and 3C. 3C waits in hold.
        pair = 16'hA53C;
        bus_m.in_data  = 8'hA5;
        bus_m.in_valid = 1'b1;
        tick();
        check("t2/ready_e0", {31'd0, bus_m.in_ready}, 32'd1);
        expect_bit("t2.b0", pair[15], 1'b0);
        bus_m.in_data = 8'h3C;
        tick();
        bus_m.in_valid = 1'b0;
        check("t2/busy_e1", {31'd0, bus_m.busy}, 32'd1);
        for (int k = 1; k < 16; k++) begin
            expect_bit($sformatf("t2.b%0d", k), pair[15-k], (k == 7) || (k == 15));
            check($sformatf("t2/ready%0d", k), {31'd0, bus_m.in_ready}, {31'd0, k >= 8});
            tick();
        end
        expect_idle("t2.end");
        $display("words a5,3c streamed back to back");

        // 3: F0 with ser_en low for 3 edges after bit 3.
        active = 0;
        bus_m.in_data  = 8'hF0;
        bus_m.in_valid = 1'b1;
        tick();
        bus_m.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_bit($sformatf("t3.b%0d", k), 1'b1, 1'b0);
            if (k < 3) tick();
        end
        bus_m.ser_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_bit($sformatf("t3.frz%0d", k), 1'b1, 1'b0);
        end
        bus_m.ser_en = 1'b1;
        for (int k = 4; k < 8; k++) begin
            tick();
            expect_bit($sformatf("t3.b%0d", k), 1'b0, k == 7);
        end
        tick();
        expect_idle("t3.end");
        check("t3/span", active, 32'd11);
        $display("word f0 streamed with 3-cycle stall");

        // 4: asynchronous reset in bit 5 while the hold register is full.
        bus_m.in_data  = 8'hC3;
        bus_m.in_valid = 1'b1;
        tick();
        bus_m.in_data = 8'h5A;
        tick();
        bus_m.in_valid = 1'b0;
        for (int k = 2; k <= 5; k++) tick();
        expect_bit("t4.b5", 1'b0, 1'b0);
        check("t4/hold_full", {31'd0, bus_m.in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        expect_idle("t4.rst");
        tick();
        rst = 1'b0;
        tick();
        expect_idle("t4.post");
        stream_word("t4", 8'h81);

        // 5: LSB-first instance with word 01.
        bus_l.in_data  = 8'h01;
        bus_l.in_valid = 1'b1;
        tick();
        bus_l.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t5.b%0d/out", k), {31'd0, bus_l.ser_out}, {31'd0, k == 0});
            check($sformatf("t5.b%0d/valid", k), {31'd0, bus_l.ser_valid}, 32'd1);
            check($sformatf("t5.b%0d/last", k), {31'd0, bus_l.ser_last}, {31'd0, k == 7});
            tick();
        end
        check("t5.end/valid", {31'd0, bus_l.ser_valid}, 32'd0);
        $display("word 01 streamed lsb first");

        // 6: 55 is offered on the end-of-word edge of C0 and loads directly.
        pair = 16'hC055;
        bus_m.in_data  = 8'hC0;
        bus_m.in_valid = 1'b1;
        tick();
        bus_m.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            expect_bit($sformatf("t6.b%0d", k), pair[15-k], (k == 7) || (k == 15));
            check($sformatf("t6/ready%0d", k), {31'd0, bus_m.in_ready}, 32'd1);
            if (k == 7) begin
                bus_m.in_data  = 8'h55;
                bus_m.in_valid = 1'b1;
            end
            tick();
            bus_m.in_valid = 1'b0;
        end
        expect_idle("t6.end");
        $display("words c0,55 streamed with direct load at boundary");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
